dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares data-RAM port A between the pipeline MEM-stage requester (cpu) and a debug/loader requester (dbg).
- Performs byte-lane alignment for sub-word stores.
- Tracks the 1-cycle synchronous read latency and returns read data to the correct owner.
- Sits between the MEM/WB segment register logic and the block-RAM instance.
- Stalls the pipeline when dbg steals the port.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles dbg may be denied before it is force-granted for one cycle (range 1..15).
- CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk in 1: system clock, all state on rising edge.
- rst in 1: synchronous, active-high reset.
- cpu_req in 1: MEM-stage access request (load or store).
- cpu_we in 4: cpu byte write mask, unaligned (LSB-based); 0 = read.
- cpu_addr in 32: cpu byte address.
- cpu_wdata in 32: cpu store data, LSB-aligned.
- cpu_stall out 1: cpu request not served this cycle; the pipeline must hold.
- cpu_rvalid out 1: cpu read data valid on cpu_rdata.
- cpu_rdata out 32: raw RAM word for cpu, unshifted; the data-extension unit aligns it.
- dbg_req in 1: debug access request.
- dbg_we in 4: debug byte write mask, word-aligned (not shifted).
- dbg_addr in 32: debug byte address (bits 1:0 ignored).
- dbg_wdata in 32: debug write word.
- dbg_gnt out 1: debug request served this cycle.
- dbg_rvalid out 1: debug read data valid.
- dbg_rdata out 32: RAM word for debug.
- ram_wea out 4: port A byte write enables.
- ram_addra out 30: port A word address.
- ram_dina out 32: port A write data.
- ram_douta in 32: port A read data, valid one cycle after address.

Behaviour:
- Grant, combinational from current inputs and registered state:
  - cpu_req and dbg_req both low: no grant; ram_wea = 0; ram_addra = cpu_addr[31:2]; ram_dina = 0.
  - Only one requests: that requester is granted.
  - Both request: cpu is granted unless starve_cnt == STARVE_LIMIT, in which case dbg is granted.
- cpu_stall = cpu_req & dbg_gnt. dbg_gnt = dbg_req & (grant is dbg).
- Cpu alignment when granted:
  - ram_wea = (cpu_we << cpu_addr[1:0]) truncated to 4 bits.
  - ram_dina = (cpu_wdata << 8*cpu_addr[1:0]) truncated to 32 bits; shifted-out bits are discarded.
  - ram_addra = cpu_addr[31:2].
- Dbg when granted: ram_wea = dbg_we, ram_dina = dbg_wdata, ram_addra = dbg_addr[31:2].
- starve_cnt (CNT_W-bit register):
  - Increments when dbg_req & !dbg_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 on dbg_gnt or when dbg_req is low.
- Read tracking, registered:
  - rd_owner_q[1:0] (00 none, 01 cpu, 10 dbg) is set on each cycle to the granted requester if its we == 0, else 00.
  - A granted write never produces rvalid.
- Read outputs:
  - cpu_rvalid = (rd_owner_q == 01); dbg_rvalid = (rd_owner_q == 10).
  - cpu_rdata = dbg_rdata = ram_douta. Consumers qualify the data by rvalid.
- Latency: request in cycle N gives rvalid and data in cycle N+1. Back-to-back reads are supported every cycle, with no bubbles.
- Reset:
  - rst high forces starve_cnt = 0 and rd_owner_q = 00.
  - While rst is high, grants are suppressed: dbg_gnt = 0, cpu_stall = 0, ram_wea = 0.
  - A read issued in the cycle before rst asserts returns no rvalid; its pending response is dropped.
- Reset values of outputs: cpu_stall 0, cpu_rvalid 0, dbg_gnt 0, dbg_rvalid 0, ram_wea 0. Rdata outputs mirror ram_douta.
- Forced dbg grant lasts exactly one cycle, then starve_cnt returns to 0 and cpu wins again. Under continuous contention the cpu stalls 1 cycle in every STARVE_LIMIT+1.
- dbg_we and dbg_addr[1:0] are never shifted. The dbg port is word-granular by definition.

Test Plan:
- cpu store, cpu_we=0001, addr=0x103, wdata=0x000000AB → same cycle ram_wea=1000, ram_dina=0xAB000000, ram_addra=0x40; next cycle cpu_rvalid=0.
- cpu load at addr 0x200 in cycle N, RAM holds 0xDEADBEEF → cycle N+1 cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dbg_rvalid=0.
- cpu_req and dbg_req held high 10 cycles, STARVE_LIMIT=4 → dbg_gnt=1 and cpu_stall=1 in cycles 5 and 10 only; all other cycles serve cpu.
- dbg only, dbg_we=1111, addr=0x13, wdata=0x12345678 → ram_wea=1111, ram_addra=0x4, ram_dina=0x12345678, dbg_gnt=1, cpu_stall=0.
- cpu_we=0011, addr=0x3, wdata=0x0000BEEF → ram_wea=1000, ram_dina=0xEF000000 (truncation check).
- dbg read granted in cycle N, rst=1 in cycle N+1 → dbg_rvalid=0 in N+1 and N+2; starve_cnt=0 and ram_wea=0 during rst.

Source files
------------

// File: rtl/dmem_port_if.sv
// Bundle of the cpu, dbg and RAM port-A signals around the data-memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// everything around it: both requesters and the block-RAM read data.
interface dmem_port_if;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dbg_req;
  logic [3:0]  dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic [3:0]  ram_wea;
  logic [29:0] ram_addra;
  logic [31:0] ram_dina;
  logic [31:0] ram_douta;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_wea, ram_addra, ram_dina,
    input  ram_douta
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_wea, ram_addra, ram_dina,
    output ram_douta
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-RAM port A arbiter between the MEM-stage cpu requester and the debug
// loader. The cpu normally wins. A starvation counter force-grants dbg for
// one cycle after STARVE_LIMIT consecutive denials. Sub-word cpu stores are
// lane-aligned onto the RAM word. Read ownership is tracked across the
// one-cycle RAM latency so that the data returns to the correct requester.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic        clk,
  input logic        rst,
  dmem_port_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } owner_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  owner_e           rd_owner_q;
  logic             grant_cpu;
  logic             grant_dbg;
  logic [3:0]       wea;
  logic [29:0]      addra;
  logic [31:0]      dina;

  // dbg is word-granular, so its byte offset is intentionally ignored.
  logic unused_dbg_offset;
  assign unused_dbg_offset = ^bus.dbg_addr[1:0];

  // Grant decision: cpu has priority unless dbg has waited STARVE_LIMIT cycles.
  // No grant is given while rst is high.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (!rst) begin
      if (bus.cpu_req && bus.dbg_req) begin
        if (starve_cnt == LIMIT) grant_dbg = 1'b1;
        else                     grant_cpu = 1'b1;
      end else begin
        grant_cpu = bus.cpu_req;
        grant_dbg = bus.dbg_req;
      end
    end
  end

  // Port A mux: the cpu byte mask and data are shifted into their lanes, and
  // bytes shifted past bit 31 are dropped. dbg is presented unshifted.
  always_comb begin
    wea   = 4'b0000;
    addra = bus.cpu_addr[31:2];
    dina  = 32'h0;
    if (grant_cpu) begin
      wea  = bus.cpu_we << bus.cpu_addr[1:0];
      dina = bus.cpu_wdata << {bus.cpu_addr[1:0], 3'b000};
    end else if (grant_dbg) begin
      wea   = bus.dbg_we;
      addra = bus.dbg_addr[31:2];
      dina  = bus.dbg_wdata;
    end
  end

  assign bus.ram_wea   = wea;
  assign bus.ram_addra = addra;
  assign bus.ram_dina  = dina;

  assign bus.dbg_gnt   = grant_dbg;
  assign bus.cpu_stall = bus.cpu_req & grant_dbg;

  // Starvation counter and read-owner tracking across the RAM latency.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      if (bus.dbg_req && !grant_dbg) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      if (grant_cpu && (bus.cpu_we == 4'b0000))      rd_owner_q <= OWN_CPU;
      else if (grant_dbg && (bus.dbg_we == 4'b0000)) rd_owner_q <= OWN_DBG;
      else                                           rd_owner_q <= OWN_NONE;
    end
  end

  // A response that is still pending when rst rises is dropped.
  assign bus.cpu_rvalid = !rst && (rd_owner_q == OWN_CPU);
  assign bus.dbg_rvalid = !rst && (rd_owner_q == OWN_DBG);
  assign bus.cpu_rdata  = bus.ram_douta;
  assign bus.dbg_rdata  = bus.ram_douta;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter. A behavioural block RAM sits on
// port A. Each issued read pushes its expected response (owner and word) onto
// a scoreboard queue, and the entry is popped and compared one cycle later.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// on the falling edge.
module tb_dmem_port_arbiter;

  localparam int LIM = 4;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   m_cnt = 0;
  logic m_gd;
  logic m_dreq;
  rsp_t exp_q[$];
  logic [31:0] mem [0:1023];

  dmem_port_if bus ();

  dmem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(int idx);
    if (idx == 32'h80) return 32'hDEADBEEF;
    return {16'(idx) ^ 16'hA5A5, ~16'(idx)};
  endfunction

  // Block-RAM model: read-first, one-cycle read latency.
  always @(posedge clk) begin
    bus.ram_douta <= mem[bus.ram_addra[9:0]];
    for (int b = 0; b < 4; b++)
      if (bus.ram_wea[b]) mem[bus.ram_addra[9:0]][8*b +: 8] <= bus.ram_dina[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic creq, input logic [3:0] cwe, input logic [31:0] caddr,
                        input logic [31:0] cwd, input logic dreq, input logic [3:0] dwe,
                        input logic [31:0] daddr, input logic [31:0] dwd, input logic r);
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.dbg_req = dreq; bus.dbg_we = dwe; bus.dbg_addr = daddr; bus.dbg_wdata = dwd;
    rst = r;
  endtask

  task automatic idle(input logic r);
    set_in(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, r);
  endtask

  // Falling-edge sample: pops last cycle's expected response and checks the
  // grant, the stall and the port-A outputs against the bench model. It then
  // pushes this cycle's expected response.
  task automatic sample();
    rsp_t       prev;
    rsp_t       nxt;
    logic       gc;
    logic       gd;
    logic [3:0] e_wea;
    logic [29:0] e_addr;
    logic [31:0] e_din;
    int         off;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      prev.owner = 2'b00; prev.data = 32'h0;
    end else begin
      prev = exp_q.pop_front();
    end
    if (rst) prev.owner = 2'b00;
    check("cpu_rvalid", bus.cpu_rvalid, prev.owner == 2'b01);
    check("dbg_rvalid", bus.dbg_rvalid, prev.owner == 2'b10);
    if (prev.owner == 2'b01) check("cpu_rdata", bus.cpu_rdata, prev.data);
    if (prev.owner == 2'b10) check("dbg_rdata", bus.dbg_rdata, prev.data);

    gc = 1'b0; gd = 1'b0;
    if (!rst) begin
      if (bus.cpu_req && bus.dbg_req) begin
        if (m_cnt == LIM) gd = 1'b1; else gc = 1'b1;
      end else begin
        gc = bus.cpu_req; gd = bus.dbg_req;
      end
    end
    e_wea = 4'h0; e_din = 32'h0; e_addr = bus.cpu_addr[31:2];
    if (gc) begin
      off = int'(bus.cpu_addr[1:0]);
      for (int b = 0; b < 4; b++)
        if (b + off < 4) begin
          e_wea[b + off] = bus.cpu_we[b];
          e_din[8*(b + off) +: 8] = bus.cpu_wdata[8*b +: 8];
        end
    end else if (gd) begin
      e_wea = bus.dbg_we; e_din = bus.dbg_wdata; e_addr = bus.dbg_addr[31:2];
    end
    check("dbg_gnt", bus.dbg_gnt, gd);
    check("cpu_stall", bus.cpu_stall, bus.cpu_req && gd);
    check("ram_wea", bus.ram_wea, e_wea);
    if (!rst) begin
      check("ram_addra", bus.ram_addra, e_addr);
      check("ram_dina", bus.ram_dina, e_din);
    end

    nxt.owner = 2'b00; nxt.data = 32'h0;
    if (gc && bus.cpu_we == 4'h0) begin
      nxt.owner = 2'b01; nxt.data = exp_word(int'(bus.cpu_addr[11:2]));
    end else if (gd && bus.dbg_we == 4'h0) begin
      nxt.owner = 2'b10; nxt.data = exp_word(int'(bus.dbg_addr[11:2]));
    end
    exp_q.push_back(nxt);
    m_gd = gd;
    m_dreq = bus.dbg_req;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) m_cnt = 0;
    else if (m_dreq && !m_gd) m_cnt = (m_cnt == LIM) ? LIM : m_cnt + 1;
    else m_cnt = 0;
    #1;
  endtask

  initial begin
    rsp_t none;
    logic [3:0] we;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = exp_word(i);
    none.owner = 2'b00; none.data = 32'h0;
    exp_q.push_back(none);
    idle(1'b1);
    #1;

    // Reset: outputs quiet.
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      sample();
      check("rst_wea", bus.ram_wea, 4'b0000);
      check("rst_stall", bus.cpu_stall, 1'b0);
      advance();
    end

    // Byte store at offset 3: mask and data land in the top lane.
    set_in(1'b1, 4'b0001, 32'h103, 32'h000000AB, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    check("st_wea", bus.ram_wea, 4'b1000);
    check("st_dina", bus.ram_dina, 32'hAB000000);
    check("st_addra", bus.ram_addra, 30'h40);
    advance();
    idle(1'b0);
    sample();
    check("st_no_rvalid", bus.cpu_rvalid, 1'b0);
    advance();

    // cpu load of 0x200 returns 0xDEADBEEF one cycle later.
    set_in(1'b1, 4'b0000, 32'h200, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    advance();
    idle(1'b0);
    sample();
    check("ld_rvalid", bus.cpu_rvalid, 1'b1);
    check("ld_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("ld_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    advance();

    // dbg-only word write: address offset ignored, nothing shifted.
    set_in(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h13, 32'h12345678, 1'b0);
    sample();
    check("dw_wea", bus.ram_wea, 4'b1111);
    check("dw_addra", bus.ram_addra, 30'h4);
    check("dw_dina", bus.ram_dina, 32'h12345678);
    check("dw_gnt", bus.dbg_gnt, 1'b1);
    check("dw_stall", bus.cpu_stall, 1'b0);
    advance();

    // Halfword store at offset 3: the upper byte is shifted out.
    set_in(1'b1, 4'b0011, 32'h3, 32'h0000BEEF, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    check("tr_wea", bus.ram_wea, 4'b1000);
    check("tr_dina", bus.ram_dina, 32'hEF000000);
    advance();

    // Continuous contention: dbg is force-granted in cycles 5 and 10 only.
    idle(1'b0); sample(); advance();
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 4'h0, 32'h400 + 32'(i) * 4, 32'h0, 1'b1, 4'h0, 32'h500 + 32'(i) * 4, 32'h0, 1'b0);
      sample();
      check("cont_gnt", bus.dbg_gnt, (i == 5) || (i == 10));
      check("cont_stall", bus.cpu_stall, (i == 5) || (i == 10));
      advance();
    end

    // A dbg read granted just before rst never returns rvalid.
    idle(1'b0); sample(); advance();
    for (int i = 1; i <= 5; i++) begin
      set_in(1'b1, 4'h0, 32'h440, 32'h0, 1'b1, 4'h0, 32'h480, 32'h0, 1'b0);
      sample();
      if (i == 5) check("rd_rst_gnt", bus.dbg_gnt, 1'b1);
      advance();
    end
    set_in(1'b1, 4'h0, 32'h440, 32'h0, 1'b1, 4'hF, 32'h480, 32'h0, 1'b1);
    sample();
    check("rd_rst_rvalid1", bus.dbg_rvalid, 1'b0);
    check("rd_rst_wea", bus.ram_wea, 4'b0000);
    check("rd_rst_gnt0", bus.dbg_gnt, 1'b0);
    advance();
    idle(1'b0);
    sample();
    check("rd_rst_rvalid2", bus.dbg_rvalid, 1'b0);
    advance();

    // A starvation count that has built up is cleared by rst.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 4'h0, 32'h404, 32'h0, 1'b1, 4'h0, 32'h408, 32'h0, 1'b0);
      sample(); advance();
    end
    set_in(1'b1, 4'h0, 32'h404, 32'h0, 1'b1, 4'h0, 32'h408, 32'h0, 1'b1);
    sample(); advance();
    idle(1'b0);
    sample();
    check("rst_cnt", 32'(dut.starve_cnt), 32'd0);
    advance();

    // Random traffic: reads in words 0x100-0x1FF, writes in words 0x200-0x2FF.
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      a  = (we == 4'h0) ? 32'h400 + 32'($urandom_range(0, 1023)) : 32'h800 + 32'($urandom_range(0, 1023));
      bus.cpu_req = ($urandom_range(0, 3) != 0); bus.cpu_we = we; bus.cpu_addr = a;
      bus.cpu_wdata = $urandom;
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      a  = (we == 4'h0) ? 32'h400 + 32'($urandom_range(0, 1023)) : 32'h800 + 32'($urandom_range(0, 1023));
      bus.dbg_req = ($urandom_range(0, 2) != 0); bus.dbg_we = we; bus.dbg_addr = a;
      bus.dbg_wdata = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
